// File: rtl/armleocpu_defines.sv
// Shared M-extension definitions: multiplier FSM state encoding and the
// funct3 codes the execute stage decodes into signed0/signed1 and the
// high/low result half select.
package armleocpu_defines;

    typedef enum logic [1:0] {
        MUL_STATE_IDLE = 2'd0,
        MUL_STATE_OP   = 2'd1,
        MUL_STATE_SIGN = 2'd2
    } mul_state_t;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

endpackage

// File: rtl/armleocpu_unsigned_multiplier.sv
// Unsigned radix-2 shift-add core. A fetch loads both operands; one
// iteration then runs per cycle. `last` is high during the cycle whose
// iteration is the final one, so the wrapper can leave its OP state on the
// same edge that commits the last partial sum. `result` is the accumulator.
// ARMLEOCPU_MULTIPLIER_EARLY_EXIT_EN: also finish once no multiplier bits remain.
module armleocpu_unsigned_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch,
    input  logic [WIDTH-1:0]     factor0,
    input  logic [WIDTH-1:0]     factor1,
    output logic                 last,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      counter;
    logic               running;

    // Final iteration: fixed count, or optionally no bits left to add.
    always_comb begin
        last = 1'b0;
        if (running) begin
`ifdef ARMLEOCPU_MULTIPLIER_EARLY_EXIT_EN
            last = (counter == CW'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
            last = (counter == CW'(WIDTH - 1));
`endif
        end
    end

    assign result = acc;

    // Operand load on fetch, then one shift-add step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            counter <= '0;
            running <= 1'b0;
        end else if (fetch) begin
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, factor0};
            mplier  <= factor1;
            counter <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            counter <= counter + 1'b1;
            if (last) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/armleocpu_multiplier.sv
// Signed/unsigned 32x32->64 multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are converted to magnitudes, multiplied by the unsigned core,
// and the product sign is restored in the SIGN stage.
// Handshake: fetch is sampled only while idle (state == MUL_STATE_IDLE);
// busy is high from the cycle after an accepted fetch until ready; ready is
// a one-cycle pulse and result holds its value until the next completion.
// ARMLEOCPU_MULTIPLIER_EARLY_EXIT_EN: core finishes once the remaining
// multiplier bits are zero (same results, shorter latency).
module armleocpu_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch,
    input  logic [WIDTH-1:0]     factor0,
    input  logic [WIDTH-1:0]     factor1,
    input  logic                 signed0,
    input  logic                 signed1,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    import armleocpu_defines::*;

    mul_state_t          state, state_next;
    logic                neg, neg_next;
    logic                busy_next, ready_next;
    logic [2*WIDTH-1:0]  result_next;

    logic                core_fetch;
    logic                core_last;
    logic [2*WIDTH-1:0]  core_result;
    logic [WIDTH-1:0]    mag0, mag1;
    logic                neg0, neg1;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which fits.
    always_comb begin
        neg0 = signed0 & factor0[WIDTH-1];
        neg1 = signed1 & factor1[WIDTH-1];
        mag0 = neg0 ? (~factor0 + 1'b1) : factor0;
        mag1 = neg1 ? (~factor1 + 1'b1) : factor1;
    end

    assign core_fetch = (state == MUL_STATE_IDLE) && fetch;

    armleocpu_unsigned_multiplier #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .fetch   (core_fetch),
        .factor0 (mag0),
        .factor1 (mag1),
        .last    (core_last),
        .result  (core_result)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_next  = state;
        neg_next    = neg;
        busy_next   = busy;
        ready_next  = 1'b0;
        result_next = result;
        case (state)
            MUL_STATE_IDLE: begin
                if (fetch) begin
                    neg_next   = neg0 ^ neg1;
                    busy_next  = 1'b1;
                    state_next = MUL_STATE_OP;
                end
            end
            MUL_STATE_OP: begin
                if (core_last) begin
                    state_next = MUL_STATE_SIGN;
                end
            end
            MUL_STATE_SIGN: begin
                result_next = neg ? (~core_result + 1'b1) : core_result;
                ready_next  = 1'b1;
                busy_next   = 1'b0;
                state_next  = MUL_STATE_IDLE;
            end
            default: begin
                state_next = MUL_STATE_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MUL_STATE_IDLE;
            neg    <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_next;
            neg    <= neg_next;
            busy   <= busy_next;
            ready  <= ready_next;
            result <= result_next;
        end
    end

endmodule

// File: tb/tb_armleocpu_multiplier.sv
// Bench for armleocpu_multiplier: directed corners plus random operands,
// checked by a scoreboard fed from a plain-arithmetic product model.
// ARMLEOCPU_MULTIPLIER_EARLY_EXIT_EN selects the expected latency rule.
module tb_armleocpu_multiplier;

    import armleocpu_defines::*;

    localparam int W = 32;

    logic            clk;
    logic            rst_n;
    logic            fetch;
    logic [W-1:0]    factor0, factor1;
    logic            signed0, signed1;
    logic            busy, ready;
    logic [2*W-1:0]  result;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [2*W-1:0] exp_q[$];
    int             exp_cyc_q[$];

    armleocpu_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fetch   (fetch),
        .factor0 (factor0),
        .factor1 (factor1),
        .signed0 (signed0),
        .signed1 (signed1),
        .busy    (busy),
        .ready   (ready),
        .result  (result)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: exact product of the operands as integers
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s0, input logic s1);
        longint ia, ib;
        ia = s0 ? longint'($signed(a)) : longint'({32'd0, a});
        ib = s1 ? longint'($signed(b)) : longint'({32'd0, b});
        return 64'(ia * ib);
    endfunction

    // cycles from fetch edge to ready
    function automatic int exp_lat(input logic [W-1:0] b, input logic s1);
        logic [W-1:0] m;
        int hi;
        m = (s1 && b[W-1]) ? (32'd0 - b) : b;
        hi = 0;
        for (int i = 0; i < W; i++) if (m[i]) hi = i;
`ifdef ARMLEOCPU_MULTIPLIER_EARLY_EXIT_EN
        return 2 + hi;
`else
        return W + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every ready pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_ready: got ready=1 at cycle %0d expected no completion", cyc);
            end else begin
                check("result", result, exp_q.pop_front());
                check("latency_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
                check("busy_at_ready", 64'(busy), 64'd0);
            end
        end
    end

    // driver: call at a negedge; request accepted at the following posedge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s0, input logic s1);
        factor0 = a;
        factor1 = b;
        signed0 = s0;
        signed1 = s1;
        fetch   = 1'b1;
        exp_q.push_back(ref_mul(a, b, s0, s1));
        exp_cyc_q.push_back(cyc + 1 + exp_lat(b, s1));
        @(posedge clk);
        #1;
        fetch   = 1'b0;
        factor0 = $urandom;
        factor1 = $urandom;
        signed0 = 1'($urandom_range(0, 1));
        signed1 = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("busy_after_fetch", 64'(busy), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 100);
        if (!ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got ready=0 expected 1");
        end
    endtask

    initial begin
        logic [2:0] f3;
        logic s0, s1;
        logic [W-1:0] a, b;

        rst_n   = 1'b0;
        fetch   = 1'b0;
        factor0 = '0;
        factor1 = '0;
        signed0 = 1'b0;
        signed1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_result", result, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed corners
        issue(32'd3, 32'd5, 1'b0, 1'b0);                        drain();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);          drain();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);          drain();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);          drain();
        issue(32'h80000000, 32'h80000000, 1'b1, 1'b1);          drain();
        issue(32'h80000000, 32'h00000001, 1'b1, 1'b1);          drain();
        issue(32'h12345678, 32'd0, 1'b0, 1'b0);                 drain();
        issue(32'h12345678, 32'd1, 1'b0, 1'b0);                 drain();
        issue(32'hDEADBEEF, 32'h80000000, 1'b0, 1'b0);          drain();

        // fetch while busy is ignored; fetch during ready is accepted
        issue(32'd7, 32'd9, 1'b0, 1'b0);
`ifdef ARMLEOCPU_MULTIPLIER_EARLY_EXIT_EN
        repeat (1) @(negedge clk);
`else
        repeat (8) @(negedge clk);
`endif
        factor0 = 32'd2;
        factor1 = 32'd2;
        signed0 = 1'b0;
        signed1 = 1'b0;
        fetch   = 1'b1;
        @(posedge clk);
        #1;
        fetch = 1'b0;
        wait_ready();
        issue(32'd2, 32'd2, 1'b0, 1'b0);
        drain();

        // asynchronous reset mid-operation discards the operation
        issue(32'h00001234, 32'hF0000001, 1'b0, 1'b0);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", 64'(ready), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_result", result, 64'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'd6, 32'd7, 1'b0, 1'b0);
        drain();

        // random operands across all four instruction signedness modes
        for (int i = 0; i < 48; i++) begin
            f3 = 3'($urandom_range(0, 3));
            case (f3)
                FUNCT3_MUL, FUNCT3_MULH: begin s0 = 1'b1; s1 = 1'b1; end
                FUNCT3_MULHSU:           begin s0 = 1'b1; s1 = 1'b0; end
                default:                 begin s0 = 1'b0; s1 = 1'b0; end
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            issue(a, b, s0, s1);
            if ($urandom_range(0, 1) == 1) begin
                wait_ready();
            end else begin
                drain();
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // global time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
